// File: rtl/cpu_pkg.sv
// Shared CPU constants: default datapath width and NZCV bit positions
// used when packing condition flags into the CPSR.
package cpu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Bit positions of the condition flags inside a packed 4-bit NZCV field.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/mac_add_flags.sv
// Combinational W-bit adder with ARM-style NZCV flag generation.
// Kept free of state so the ALU can reuse it unchanged.
module mac_add_flags
  import cpu_pkg::*;
#(
  parameter int W = DEFAULT_WIDTH
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic [3:0]   nzcv_o
);

  logic [W:0] full_sum;

  // Unsigned add with an extra bit for carry; overflow when both addends
  // share a sign and the truncated sum does not.
  always_comb begin
    full_sum         = {1'b0, a_i} + {1'b0, b_i};
    sum_o            = full_sum[W-1:0];
    nzcv_o           = '0;
    nzcv_o[FLAG_N]   = full_sum[W-1];
    nzcv_o[FLAG_Z]   = (full_sum[W-1:0] == '0);
    nzcv_o[FLAG_C]   = full_sum[W];
    nzcv_o[FLAG_V]   = (a_i[W-1] == b_i[W-1]) && (full_sum[W-1] != a_i[W-1]);
  end

endmodule

// File: rtl/mac_unit.sv
// Two-stage pipelined multiply-accumulate: result = low WIDTH bits of
// in1*in2 + acc, with NZCV flags describing the accumulate add.
// Stage 1 registers the truncated product, stage 2 registers the sum and flags.
module mac_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] acc,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             overflow_flag,
  output logic             negative_flag
);

  // Only the low WIDTH product bits matter, so the multiply is sized to
  // WIDTH; that makes signed and unsigned operands give the same result.
  logic [WIDTH-1:0] prod_d;
  assign prod_d = in1 * in2;

  logic [WIDTH-1:0] prod_q;
  logic [WIDTH-1:0] acc_q;
  logic             valid1_q;

  logic [WIDTH-1:0] sum_d;
  logic [3:0]       nzcv_d;

  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             out_valid_q;

  // Stage 1: capture product, addend and valid every cycle (no stall path).
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q   <= '0;
      acc_q    <= '0;
      valid1_q <= 1'b0;
    end else begin
      prod_q   <= prod_d;
      acc_q    <= acc;
      valid1_q <= in_valid;
    end
  end

  mac_add_flags #(
    .W (WIDTH)
  ) u_add_flags (
    .a_i    (prod_q),
    .b_i    (acc_q),
    .sum_o  (sum_d),
    .nzcv_o (nzcv_d)
  );

  // Stage 2: result and flags update only for a valid op, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= valid1_q;
      if (valid1_q) begin
        result_q <= sum_d;
        flags_q  <= nzcv_d;
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign result        = result_q;
  assign negative_flag = flags_q[FLAG_N];
  assign zero_flag     = flags_q[FLAG_Z];
  assign carry_flag    = flags_q[FLAG_C];
  assign overflow_flag = flags_q[FLAG_V];

endmodule

// File: tb/tb_mac_unit.sv
// Scoreboard bench for mac_unit: a driver pushes expected results computed
// with plain wide arithmetic, a monitor pops and compares on out_valid and
// checks that outputs hold while out_valid is low.
module tb_mac_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in1, in2, acc;
  logic        out_valid;
  logic [31:0] result;
  logic        zero_flag, carry_flag, overflow_flag, negative_flag;

  always #5 clk = ~clk;

  mac_unit #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in1           (in1),
    .in2           (in2),
    .acc           (acc),
    .out_valid     (out_valid),
    .result        (result),
    .zero_flag     (zero_flag),
    .carry_flag    (carry_flag),
    .overflow_flag (overflow_flag),
    .negative_flag (negative_flag)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  f;   // {N,Z,C,V}
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic        mon_en   = 1'b0;
  logic [31:0] hold_res = '0;
  logic [3:0]  hold_f   = '0;
  int          n_out    = 0;

  wire [3:0] dut_f = {negative_flag, zero_flag, carry_flag, overflow_flag};

  // Reference model: plain 64-bit arithmetic on the architectural definitions.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    exp_t            e;
    longint unsigned p, s;
    longint          sp, sc, ss;
    p  = ({32'd0, a} * {32'd0, b}) % 64'h1_0000_0000;
    s  = p + {32'd0, c};
    sp = longint'($signed(p[31:0]));
    sc = longint'($signed(c));
    ss = sp + sc;
    e.res = s[31:0];
    e.f[3] = s[31];
    e.f[2] = (s[31:0] == 32'd0);
    e.f[1] = (s >= 64'h1_0000_0000);
    e.f[0] = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    return e;
  endfunction

  task automatic issue(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    @(negedge clk); #1;
    rst      = 1'b0;
    in_valid = v;
    in1      = a;
    in2      = b;
    acc      = c;
    if (v) sb_q.push_back(model(a, b, c));
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s out_valid: got %b want 0", tag, out_valid);
    end
    checks++;
    if (result !== 32'd0) begin
      failures++;
      $display("FAIL %s result: got %h want 00000000", tag, result);
    end
    checks++;
    if (dut_f !== 4'b0000) begin
      failures++;
      $display("FAIL %s nzcv: got %b want 0000", tag, dut_f);
    end
  endtask

  // Monitor: compare on out_valid, otherwise require outputs to hold.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (out_valid === 1'b1) begin
          n_out++;
          if (sb_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_out_valid: got result=%h nzcv=%b want no output", result, dut_f);
          end else begin
            e = sb_q.pop_front();
            checks++;
            if (result !== e.res) begin
              failures++;
              $display("FAIL result #%0d: got %h want %h", n_out, result, e.res);
            end
            checks++;
            if (dut_f !== e.f) begin
              failures++;
              $display("FAIL nzcv #%0d: got %b want %b (result %h)", n_out, dut_f, e.f, e.res);
            end
            $display("out #%0d result=%h nzcv=%b", n_out, result, dut_f);
            hold_res = e.res;
            hold_f   = e.f;
          end
        end else begin
          checks++;
          if (out_valid !== 1'b0 || result !== hold_res || dut_f !== hold_f) begin
            failures++;
            $display("FAIL hold: got v=%b result=%h nzcv=%b want v=0 result=%h nzcv=%b",
                     out_valid, result, dut_f, hold_res, hold_f);
          end
        end
      end
    end
  end

  initial begin : driver
    int waited;
    rst = 1'b1; in_valid = 1'b1; in1 = 32'd3; in2 = 32'd5; acc = 32'd7;

    // 1. Reset held two cycles with in_valid high.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    #1;
    mon_en = 1'b1;

    // 2. Square sweep; 3. accumulate sweep.
    for (int i = 0; i < 10; i++) issue(1'b1, i, i, 32'd0);
    for (int i = 0; i < 10; i++) issue(1'b1, i, i, 32'd1);
    issue(1'b0, 32'd0, 32'd0, 32'd0);

    // 4. Carry/zero; 5. overflow/negative and truncated product.
    issue(1'b1, 32'hFFFF_FFFF, 32'd1, 32'd1);
    issue(1'b1, 32'h7FFF_FFFF, 32'd1, 32'd1);
    issue(1'b1, 32'h0001_0000, 32'h0001_0000, 32'd0);
    issue(1'b0, 32'd0, 32'd0, 32'd0);
    issue(1'b0, 32'd0, 32'd0, 32'd0);

    // Randomized traffic with bubbles and a mix of magnitudes.
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a, b, c;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom;
      c = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      issue($urandom_range(0, 3) != 0, a, b, c);
    end

    // 6. Back-to-back ops, then a one-cycle reset with two ops in flight.
    issue(1'b1, 32'd11, 32'd12, 32'd13);
    issue(1'b1, 32'hDEAD_BEEF, 32'd3, 32'h1234_5678);
    issue(1'b1, 32'd100, 32'd200, 32'd300);          // in stage 1 when reset hits
    @(negedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; in1 = 32'd9; in2 = 32'd9; acc = 32'd9;  // discarded
    sb_q.delete();
    hold_res = '0;
    hold_f   = '0;
    issue(1'b1, 32'd6, 32'd7, 32'd8);                // completes normally
    issue(1'b0, 32'd0, 32'd0, 32'd0);

    // Drain: all expected outputs must appear within a bounded window.
    waited = 0;
    while (sb_q.size() != 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d outputs still pending want 0", sb_q.size());
    end
    repeat (2) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
